// File: rtl/xnorpop_pkg.sv
// xnorpop_pkg: shared constants and state encoding for the XNOR-popcount
// accumulator slice.
//   POP_W   - width of one popcount beat
//   POP_MAX - largest legal popcount of one 128-bit word
//   state_t - accumulator FSM states
package xnorpop_pkg;

    localparam int unsigned POP_W   = 8;
    localparam int unsigned POP_MAX = 128;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/xnorpop_sat_add.sv
// xnorpop_sat_add: combinational saturating add of an ACC_W-bit partial sum
// and one POP_W-bit popcount.
//   a   in  ACC_W : running sum
//   b   in  POP_W : popcount beat
//   sum out ACC_W : a + b clamped at 2^ACC_W-1
//   ovf out 1     : the clamp was applied
module xnorpop_sat_add
    import xnorpop_pkg::*;
#(
    parameter int unsigned ACC_W = 16
) (
    input  logic [ACC_W-1:0] a,
    input  logic [POP_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W:0] raw;

    always_comb begin
        raw = {1'b0, a} + (ACC_W + 1)'(b);
        ovf = raw[ACC_W];
        sum = raw[ACC_W] ? '1 : raw[ACC_W-1:0];
    end

endmodule

// File: rtl/xnorpop_accum.sv
// xnorpop_accum: sums per-word popcount beats across a binarized dot-product
// vector, then registers the saturated total with a threshold activation bit
// behind a valid/ready output.
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid/in_ready   : beat handshake (in_ready is purely registered-state)
//   in_pop, in_last     : popcount beat and end-of-vector marker
//   thresh              : activation threshold, sampled on a vector's first beat
//   out_valid/out_ready : result handshake
//   out_sum, out_act    : saturated sum and (sum >= threshold)
//   out_words           : beats in the vector
//   out_ovf, out_trunc  : saturation seen / vector cut at MAX_WORDS
//   err                 : sticky, an accepted beat exceeded POP_MAX
module xnorpop_accum
    import xnorpop_pkg::*;
#(
    parameter  int unsigned ACC_W     = 16,
    parameter  int unsigned MAX_WORDS = 64,
    localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [POP_W-1:0] in_pop,
    input  logic             in_last,
    input  logic [ACC_W-1:0] thresh,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_act,
    output logic [CNT_W-1:0] out_words,
    output logic             out_ovf,
    output logic             out_trunc,
    output logic             err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] thresh_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    logic             accept;
    logic             first;
    logic             terminal;
    logic [ACC_W-1:0] add_a;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;
    logic [ACC_W-1:0] thresh_eff;

    // Feeding zero on the first beat lets one adder serve both the load
    // and the accumulate case.
    xnorpop_sat_add #(
        .ACC_W(ACC_W)
    ) u_sat_add (
        .a  (add_a),
        .b  (in_pop),
        .sum(add_sum),
        .ovf(add_ovf)
    );

    always_comb begin
        in_ready   = (state_q == ACCUM);
        accept     = in_valid && in_ready;
        first      = (cnt_q == '0);
        add_a      = first ? '0 : acc_q;
        cnt_next   = cnt_q + CNT_W'(1);
        terminal   = in_last || (cnt_next == MAX_CNT);
        ovf_next   = ovf_q || add_ovf;
        // A single-beat vector compares against the live threshold, since
        // thresh_q is only loaded on that same edge.
        thresh_eff = first ? thresh : thresh_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (accept && terminal) state_d = HOLD;
            HOLD:    if (out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q     <= '0;
            thresh_q  <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_act   <= 1'b0;
            out_words <= '0;
            out_ovf   <= 1'b0;
            out_trunc <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (accept && first) begin
                thresh_q <= thresh;
            end
            if (accept && (in_pop > POP_W'(POP_MAX))) begin
                err <= 1'b1;
            end
            if (accept) begin
                if (terminal) begin
                    acc_q     <= '0;
                    cnt_q     <= '0;
                    ovf_q     <= 1'b0;
                    out_valid <= 1'b1;
                    out_sum   <= add_sum;
                    out_act   <= (add_sum >= thresh_eff);
                    out_words <= cnt_next;
                    out_ovf   <= ovf_next;
                    out_trunc <= !in_last;
                end else begin
                    acc_q <= add_sum;
                    cnt_q <= cnt_next;
                    ovf_q <= ovf_next;
                end
            end else if ((state_q == HOLD) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xnorpop_accum.sv
// tb_xnorpop_accum: directed bench for xnorpop_accum. Three instances share
// the clock and reset: defaults, ACC_W=8 (saturation), MAX_WORDS=4
// (truncation). Inputs change 1 time unit after a rising edge; outputs are
// checked at that same point, well away from the next edge.
module tb_xnorpop_accum;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // default instance
    logic        v0, r0, l0, ir0, ov0, act0, ovf0, tr0, err0;
    logic [7:0]  p0;
    logic [15:0] th0, sum0;
    logic [6:0]  words0;

    // ACC_W = 8 instance
    logic        v8, r8, l8, ir8, ov8, act8, ovf8, tr8, err8;
    logic [7:0]  p8, th8, sum8;
    logic [6:0]  words8;

    // MAX_WORDS = 4 instance
    logic        v4, r4, l4, ir4, ov4, act4, ovf4, tr4, err4;
    logic [7:0]  p4;
    logic [15:0] th4, sum4;
    logic [2:0]  words4;

    xnorpop_accum u0 (
        .clk(clk), .reset(reset),
        .in_valid(v0), .in_ready(ir0), .in_pop(p0), .in_last(l0), .thresh(th0),
        .out_valid(ov0), .out_ready(r0), .out_sum(sum0), .out_act(act0),
        .out_words(words0), .out_ovf(ovf0), .out_trunc(tr0), .err(err0)
    );

    xnorpop_accum #(.ACC_W(8)) u8 (
        .clk(clk), .reset(reset),
        .in_valid(v8), .in_ready(ir8), .in_pop(p8), .in_last(l8), .thresh(th8),
        .out_valid(ov8), .out_ready(r8), .out_sum(sum8), .out_act(act8),
        .out_words(words8), .out_ovf(ovf8), .out_trunc(tr8), .err(err8)
    );

    xnorpop_accum #(.MAX_WORDS(4)) u4 (
        .clk(clk), .reset(reset),
        .in_valid(v4), .in_ready(ir4), .in_pop(p4), .in_last(l4), .thresh(th4),
        .out_valid(ov4), .out_ready(r4), .out_sum(sum4), .out_act(act4),
        .out_words(words4), .out_ovf(ovf4), .out_trunc(tr4), .err(err4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] held_sum;

    initial begin
        reset = 1'b1;
        v0 = 0; r0 = 0; l0 = 0; p0 = '0; th0 = '0;
        v8 = 0; r8 = 0; l8 = 0; p8 = '0; th8 = '0;
        v4 = 0; r4 = 0; l4 = 0; p4 = '0; th4 = '0;
        tick();
        tick();
        chk("rst_in_ready", ir0, 1);
        chk("rst_out_valid", ov0, 0);
        chk("rst_out_sum", sum0, 0);
        chk("rst_out_words", words0, 0);
        chk("rst_err", err0, 0);
        reset = 1'b0;
        tick();

        // 4 x 128, thresh 300
        th0 = 16'd300; v0 = 1; p0 = 8'd128; l0 = 0;
        tick(); th0 = 16'd0;     // threshold sampled on the first beat only
        tick();
        tick(); l0 = 1;
        chk("t1_no_early_valid", ov0, 0);
        tick(); v0 = 0; l0 = 0;
        chk("t1_valid", ov0, 1);
        chk("t1_sum", sum0, 512);
        chk("t1_act", act0, 1);
        chk("t1_words", words0, 4);
        chk("t1_ovf", ovf0, 0);
        chk("t1_trunc", tr0, 0);
        chk("t1_in_ready_hold", ir0, 0);
        r0 = 1;
        tick(); r0 = 0;
        chk("t1_valid_drop", ov0, 0);
        chk("t1_in_ready_back", ir0, 1);

        // single beat 64, thresh 65
        th0 = 16'd65; v0 = 1; p0 = 8'd64; l0 = 1;
        tick(); v0 = 0; l0 = 0;
        chk("t2_sum", sum0, 64);
        chk("t2_act", act0, 0);
        chk("t2_words", words0, 1);
        r0 = 1;
        tick(); r0 = 0;

        // 100 + 100 against thresh 200: equality activates
        th0 = 16'd200; v0 = 1; p0 = 8'd100; l0 = 0;
        tick(); l0 = 1;
        tick(); v0 = 0; l0 = 0;
        chk("t3_sum", sum0, 200);
        chk("t3_act_eq", act0, 1);
        chk("t3_words", words0, 2);

        // backpressure 5 cycles with a beat pending
        held_sum = sum0;
        th0 = 16'd0; v0 = 1; p0 = 8'd7; l0 = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_in_ready", ir0, 0);
            chk("bp_valid", ov0, 1);
            chk("bp_sum_stable", sum0, held_sum);
            chk("bp_words_stable", words0, 2);
        end
        r0 = 1;
        tick(); r0 = 0;
        chk("bp_release_valid", ov0, 0);
        chk("bp_release_ready", ir0, 1);
        tick(); v0 = 0; l0 = 0;
        chk("bp_next_valid", ov0, 1);
        chk("bp_next_sum", sum0, 7);
        chk("bp_next_words", words0, 1);
        r0 = 1;
        tick(); r0 = 0;

        // ACC_W=8: 200 + 100 saturates
        th8 = 8'd0; v8 = 1; p8 = 8'd200; l8 = 0;
        tick(); p8 = 8'd100; l8 = 1;
        tick(); v8 = 0; l8 = 0;
        chk("sat_valid", ov8, 1);
        chk("sat_sum", sum8, 255);
        chk("sat_ovf", ovf8, 1);
        chk("sat_words", words8, 2);
        chk("sat_err_200", err8, 1);
        r8 = 1;
        tick(); r8 = 0;
        v8 = 1; p8 = 8'd10; l8 = 1;
        tick(); v8 = 0; l8 = 0;
        chk("sat_next_sum", sum8, 10);
        chk("sat_next_ovf", ovf8, 0);

        // MAX_WORDS=4: beats of 1 without in_last
        th4 = 16'd0; v4 = 1; p4 = 8'd1; l4 = 0;
        tick(); tick(); tick();
        chk("tr_no_early_valid", ov4, 0);
        tick();
        chk("tr_valid", ov4, 1);
        chk("tr_sum", sum4, 4);
        chk("tr_words", words4, 4);
        chk("tr_trunc", tr4, 1);
        chk("tr_in_ready", ir4, 0);
        r4 = 1;
        tick(); r4 = 0;
        chk("tr_release", ov4, 0);
        tick(); tick(); l4 = 1;     // beats 5 and 6 accepted
        chk("tr_second_pending", ov4, 0);
        tick(); v4 = 0; l4 = 0;
        chk("tr2_sum", sum4, 3);
        chk("tr2_words", words4, 3);
        chk("tr2_trunc", tr4, 0);

        // illegal popcount then reset mid-vector
        v0 = 1; p0 = 8'd200; l0 = 0;
        tick(); p0 = 8'd5;
        chk("err_set", err0, 1);
        tick(); v0 = 0;
        chk("err_held", err0, 1);
        chk("err_no_result", ov0, 0);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_err", err0, 0);
        chk("rst_mid_valid", ov0, 0);
        chk("rst_mid_ready", ir0, 1);
        tick();
        reset = 1'b0;
        tick();
        v0 = 1; p0 = 8'd3; l0 = 1; th0 = 16'd3;
        tick(); v0 = 0; l0 = 0;
        chk("post_rst_sum", sum0, 3);
        chk("post_rst_words", words0, 1);
        chk("post_rst_act", act0, 1);

        // reset while holding a result
        #2 reset = 1'b1;
        #1;
        chk("rst_hold_valid", ov0, 0);
        chk("rst_hold_sum", sum0, 0);
        tick();
        reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xnorpop_accum.md
# xnorpop_accum

Sequential accumulator downstream of the 128-bit XNOR-popcount stage. Each beat is one 8-bit popcount, for one 128-bit word of a binarized dot product. The block sums beats across a multi-word vector and registers the total with a threshold activation bit. The result is presented through a valid/ready output.

## Interface
Parameters:
- ACC_W, 16: accumulator and result width; saturating.
- MAX_WORDS, 64: maximum beats per vector; the beat at this count is forced to be the last.

Ports:
- clk  in  1: single clock; all state updates on its rising edge.
- reset  in  1: asynchronous, active-high reset.
- in_valid  in  1: popcount beat valid.
- in_ready  out  1: block accepts the beat this cycle.
- in_pop  in  8: popcount of one 128-bit word; legal range 0..128.
- in_last  in  1: final beat of the vector.
- thresh  in  ACC_W: activation threshold; sampled on the first beat of each vector.
- out_valid  out  1: result register holds an unconsumed result.
- out_ready  in  1: consumer accepts the result.
- out_sum  out  ACC_W: saturated sum of the vector's popcounts.
- out_act  out  1: out_sum >= sampled threshold.
- out_words  out  clog2(MAX_WORDS+1): number of beats in the vector.
- out_ovf  out  1: accumulation saturated during the vector.
- out_trunc  out  1: vector was ended by MAX_WORDS, not by in_last.
- err  out  1: sticky; set when any accepted in_pop exceeds 128; cleared only by reset.

## Operation
- Two states: ACCUM and HOLD. Reset state is ACCUM.
- A beat is accepted on the cycle where in_valid and in_ready are both high.
- In ACCUM, in_ready = 1. In HOLD, in_ready = 0.
- On the first beat of a vector (word count == 0):
  - acc <= in_pop.
  - thresh_q <= thresh.
  - word count <= 1.
- On each later beat:
  - acc <= sat(acc + in_pop).
  - word count += 1.
- Saturation:
  - sat() clamps at 2^ACC_W-1.
  - Any clamp sets ovf_q, which persists until the vector ends.
- Illegal beat: in_pop > 128 is still accumulated as given, and sets err.
- A beat is terminal when either:
  - in_last = 1, or
  - the beat makes word count == MAX_WORDS.
- A terminal beat that has in_last = 0 sets out_trunc.
- On a terminal beat, the output register loads from the post-add values:
  - out_sum = final acc.
  - out_act = (final acc >= thresh_q).
  - out_words = final count.
  - out_ovf and out_trunc as above.
- Also on a terminal beat:
  - out_valid <= 1, and the state moves to HOLD.
  - acc, count and ovf_q clear to 0 for the next vector.
- In HOLD with out_ready = 1:
  - out_valid <= 0 and the state moves to ACCUM.
  - No beat is accepted in that cycle.
- Out-register fields stay stable while out_valid = 1.
- Single-beat vector (first beat with in_last = 1): the result equals in_pop, and out_words = 1.

## Timing
- Reset values: all outputs 0 except in_ready = 1; acc = 0, count = 0, thresh_q = 0.
- Latency: out_valid rises 1 cycle after the terminal beat is accepted.
- Throughput:
  - One beat per cycle within a vector.
  - A terminal beat accepted at cycle T can be followed by the next vector's first beat at T+2 at the earliest (out_ready high at T+1).
- in_ready depends only on registered state, never combinationally on in_valid.
- Backpressure: out_ready low holds HOLD indefinitely. Outputs are unchanged and in_ready stays 0.
- Reset asserted mid-vector or in HOLD:
  - Immediately clears the partial sum and out_valid.
  - The partial vector is discarded; no result is produced for it.

## Structure
- Package xnorpop_pkg holds:
  - POP_W = 8 and POP_MAX = 128.
  - The state enum {ACCUM, HOLD}.
- One sub-module, xnorpop_sat_add:
  - Combinational ACC_W + 8-bit saturating add.
  - Outputs the clamped sum and an overflow flag.
- FSM, counters and output register live in the top module.

## Test plan
- 4 beats of 128 (last on beat 4), thresh = 300:
  - out_sum = 512, out_act = 1, out_words = 4, out_ovf = 0.
  - out_valid rises 1 cycle after beat 4.
- Single beat in_pop = 64 with in_last, thresh = 65: out_sum = 64, out_act = 0, out_words = 1.
- ACC_W = 8, beats 200 then 100:
  - out_sum = 255, out_ovf = 1.
  - The next vector reports out_ovf = 0.
- MAX_WORDS = 4, 6 beats of 1 with no in_last:
  - First result: out_sum = 4, out_words = 4, out_trunc = 1.
  - Second vector starts with beats 5 and 6.
- out_ready held low 5 cycles after a result:
  - in_ready = 0 and outputs stable throughout.
  - The next vector is accepted 1 cycle after out_ready rises.
- in_pop = 200 accepted → err = 1 and held; reset mid-vector → out_valid = 0, err = 0, and no partial result is emitted.
